// File: rtl/alu_exec_unit_pkg.sv
// alu_exec_unit_pkg: aluCtl operation codes and FSM state encoding shared by the execute stage.
package alu_exec_unit_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_SLL = 4'b1000,
        OP_SRL = 4'b1001,
        OP_SRA = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Low two code bits select shift kind: 00=SLL, 01=SRL, 10=SRA.
    localparam logic [1:0] SH_LEFT  = 2'b00;
    localparam logic [1:0] SH_ARITH = 2'b10;

endpackage

// File: rtl/alu_exec_unit_shift_step.sv
// alu_shift_step: single-position shift of a word, left or right, logical or arithmetic.
module alu_shift_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] d,
    input  logic            left,
    input  logic            arith,
    output logic [XLEN-1:0] q
);

    always_comb begin
        q = left ? {d[XLEN-2:0], 1'b0} : {arith & d[XLEN-1], d[XLEN-1:1]};
    end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage with single-cycle ALU ops and bit-serial shifts over valid/ready.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      aluCtl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            zero_q, zero_d;
    logic            ill_q, ill_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [1:0]      sop_q, sop_d;

    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_r, sh_in, sh_out;
    logic [1:0]      cur_op;
    logic            legal, is_shift;

    assign shamt    = b[SHW-1:0];
    assign is_shift = aluCtl inside {OP_SLL, OP_SRL, OP_SRA};
    assign legal    = is_shift || (aluCtl inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT});

    always_comb begin
        alu_r = aluCtl == OP_AND ? a & b :
                aluCtl == OP_OR  ? a | b :
                aluCtl == OP_ADD ? a + b :
                aluCtl == OP_SUB ? a - b :
                aluCtl == OP_SLT ? {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)} : '0;
    end

    // The first shift is folded into the accept cycle so latency equals shamt.
    assign sh_in  = state_q == ST_IDLE ? a : res_q;
    assign cur_op = state_q == ST_IDLE ? aluCtl[1:0] : sop_q;

    alu_shift_step #(.XLEN(XLEN)) u_shift (
        .d     (sh_in),
        .left  (cur_op == SH_LEFT),
        .arith (cur_op == SH_ARITH),
        .q     (sh_out)
    );

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        zero_d  = zero_q;
        ill_d   = ill_q;
        cnt_d   = cnt_q;
        sop_d   = sop_q;
        case (state_q)
            ST_IDLE: if (in_valid) begin
                ill_d = !legal;
                sop_d = aluCtl[1:0];
                if (is_shift && shamt == '0) begin
                    res_d   = a;
                    zero_d  = a == '0;
                    state_d = ST_DONE;
                end else if (is_shift) begin
                    res_d   = sh_out;
                    zero_d  = sh_out == '0;
                    cnt_d   = shamt - 1'b1;
                    state_d = shamt == SHW'(1) ? ST_DONE : ST_SHIFT;
                end else begin
                    res_d   = alu_r;
                    zero_d  = alu_r == '0;
                    state_d = ST_DONE;
                end
            end
            ST_SHIFT: begin
                res_d   = sh_out;
                zero_d  = sh_out == '0;
                cnt_d   = cnt_q - 1'b1;
                state_d = cnt_q == SHW'(1) ? ST_DONE : ST_SHIFT;
            end
            ST_DONE: state_d = out_ready ? ST_IDLE : ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            zero_q  <= 1'b0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
            sop_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
            sop_q   <= sop_d;
        end
    end

    assign in_ready  = state_q == ST_IDLE;
    assign out_valid = state_q == ST_DONE;
    assign result    = res_q;
    assign zero      = zero_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: randomized and directed checks of alu_exec_unit against a one-shot arithmetic model.
module tb_alu_exec_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [3:0]      alu_ctl = 4'b0;
    logic [XLEN-1:0] a = '0;
    logic [XLEN-1:0] b = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluCtl    (alu_ctl),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [3:0] ctl, input logic [31:0] x, input logic [31:0] y);
        case (ctl)
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b0010: return x + y;
            4'b0110: return x - y;
            4'b0111: return 32'($signed(x) < $signed(y));
            4'b1000: return x << y[4:0];
            4'b1001: return x >> y[4:0];
            4'b1010: return $signed(x) >>> y[4:0];
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit is_legal(input logic [3:0] ctl);
        return ctl inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1010};
    endfunction

    task automatic run_op(input logic [3:0] ctl, input logic [31:0] av, input logic [31:0] bv, input int hold);
        logic [31:0] er;
        int          el;
        int          lat;
        er = ref_res(ctl, av, bv);
        el = (ctl inside {4'b1000, 4'b1001, 4'b1010} && bv[4:0] != 0) ? int'(bv[4:0]) : 1;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        alu_ctl   = ctl;
        a         = av;
        b         = bv;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'($urandom_range(0, 1));
        a        = $urandom;
        b        = $urandom;
        alu_ctl  = 4'($urandom);
        lat = 1;
        while (!out_valid && lat <= XLEN + 2) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(el));
        chk("result", result, er);
        chk("zero", 32'(zero), 32'(er == 0));
        chk("illegal", 32'(illegal), 32'(!is_legal(ctl)));
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_result", result, er);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    logic [3:0] codes [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1010};

    initial begin
        in_valid = 1'b1;
        alu_ctl  = 4'b0010;
        a        = 32'd5;
        b        = 32'd7;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;

        run_op(4'b0010, 32'd5, 32'd7, 0);
        run_op(4'b0110, 32'd9, 32'd9, 0);
        run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(4'b1010, 32'h8000_0000, 32'd4, 0);
        run_op(4'b1000, 32'h1234_5678, 32'h0000_0100, 0);
        run_op(4'b1001, 32'h8000_0000, 32'd31, 0);
        run_op(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 5);
        run_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 1);
        run_op(4'b0001, 32'h0000_0001, 32'h0000_0002, 0);
        run_op(4'b1010, 32'h7000_0000, 32'd1, 0);

        alu_ctl  = 4'b1000;
        a        = 32'hDEAD_BEEF;
        b        = 32'd20;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
            chk("mid_shift_no_valid", 32'(out_valid), 32'd0);
        end
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        chk("async_rst_result", result, 32'd0);
        chk("async_rst_illegal", 32'(illegal), 32'd0);
        repeat (25) begin
            @(posedge clk);
            #1;
            chk("rst_held_no_valid", 32'(out_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(4'b0110, 32'd100, 32'd58, 0);

        for (int i = 0; i < 150; i++) begin
            int          r;
            logic [3:0]  ctl;
            logic [31:0] bv;
            r   = $urandom_range(0, 9);
            ctl = r < 8 ? codes[r] : 4'($urandom);
            bv  = $urandom;
            if ($urandom_range(0, 3) == 0) bv = 32'($urandom_range(0, 2));
            run_op(ctl, $urandom_range(0, 3) == 0 ? 32'h0 : $urandom, bv, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
